// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs the data-memory handshake, formats store lanes and
// load data, and registers the write-back value as the MEM/WB pipeline slot.
module mem_access_stage #(
  parameter int          TIMEOUT_CYCLES = 0,
  parameter logic [31:0] PC_INC         = 32'd4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  input  logic [4:0]  IN_RD,
  input  logic [31:0] IN_PC,
  input  logic [31:0] IN_ALU_RESULT,
  input  logic [31:0] IN_DATA2,
  input  logic [31:0] IN_IMMEDIATE,
  input  logic        IN_DATAMEMSEL,
  input  logic [3:0]  IN_READ_WRITE,
  input  logic [1:0]  IN_WB_SEL,
  input  logic        IN_REG_WRITE_EN,
  output logic        STALL_OUT,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  output logic [3:0]  DMEM_BE,
  input  logic        DMEM_READY,
  input  logic        DMEM_RVALID,
  input  logic [31:0] DMEM_RDATA,
  output logic        OUT_VALID,
  output logic [4:0]  OUT_RD,
  output logic [31:0] OUT_WB_DATA,
  output logic        OUT_REG_WRITE_EN,
  output logic        OUT_MISALIGN,
  output logic        OUT_BUS_ERR
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA} state_t;
  state_t state, state_nxt;

  logic [4:0]  h_rd;
  logic [31:0] h_pc, h_alu, h_data2, h_imm;
  logic [3:0]  h_rw;
  logic [1:0]  h_wbsel;
  logic        h_we;
  logic [31:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      h_rd <= '0; h_pc <= '0; h_alu <= '0; h_data2 <= '0; h_imm <= '0;
      h_rw <= '0; h_wbsel <= '0; h_we <= 1'b0;
    end else if (state == IDLE) begin
      h_rd <= IN_RD; h_pc <= IN_PC; h_alu <= IN_ALU_RESULT; h_data2 <= IN_DATA2;
      h_imm <= IN_IMMEDIATE; h_rw <= IN_READ_WRITE; h_wbsel <= IN_WB_SEL;
      h_we <= IN_REG_WRITE_EN;
    end
  end

  // In IDLE the retire path works straight off the EX/MEM inputs (latency 1).
  logic        in_idle;
  logic [4:0]  s_rd;
  logic [31:0] s_pc, s_alu, s_imm;
  logic [1:0]  s_wbsel;
  logic        s_we, mis_in;
  assign in_idle = (state == IDLE);
  assign s_rd    = in_idle ? IN_RD           : h_rd;
  assign s_pc    = in_idle ? IN_PC           : h_pc;
  assign s_alu   = in_idle ? IN_ALU_RESULT   : h_alu;
  assign s_imm   = in_idle ? IN_IMMEDIATE    : h_imm;
  assign s_wbsel = in_idle ? IN_WB_SEL       : h_wbsel;
  assign s_we    = in_idle ? IN_REG_WRITE_EN : h_we;
  assign mis_in  = (IN_READ_WRITE[1:0] == 2'b01 && IN_ALU_RESULT[0]) ||
                   (IN_READ_WRITE[1] && IN_ALU_RESULT[1:0] != 2'b00);

  logic tmo;
  assign tmo = (TIMEOUT_CYCLES != 0) && (cnt >= 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          cnt <= '0;
    else if (in_idle) cnt <= '0;
    else              cnt <= cnt + 32'd1;
  end

  logic retire, misal, bus_err;
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    misal     = 1'b0;
    bus_err   = 1'b0;
    case (state)
      IDLE: if (IN_VALID) begin
        if (IN_DATAMEMSEL && !mis_in) state_nxt = REQ;
        else begin
          retire = 1'b1;
          misal  = IN_DATAMEMSEL;
        end
      end
      REQ: if (DMEM_READY) begin
        if (h_rw[3]) begin retire = 1'b1; state_nxt = IDLE; end
        else state_nxt = WAIT_DATA;
      end else if (tmo) begin
        retire = 1'b1; bus_err = 1'b1; state_nxt = IDLE;
      end
      WAIT_DATA: if (DMEM_RVALID) begin
        retire = 1'b1; state_nxt = IDLE;
      end else if (tmo) begin
        retire = 1'b1; bus_err = 1'b1; state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Store lane steering and load extraction, both keyed by addr[1:0].
  logic [31:0] wdata, ld_data;
  logic [3:0]  be;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  always_comb begin
    wdata = h_data2;
    be    = 4'b1111;
    if (h_rw[3]) begin
      case (h_rw[1:0])
        2'b00: begin wdata = {4{h_data2[7:0]}};  be = 4'b0001 << h_alu[1:0]; end
        2'b01: begin wdata = {2{h_data2[15:0]}}; be = h_alu[1] ? 4'b1100 : 4'b0011; end
        default: ;
      endcase
    end
    ld_b = DMEM_RDATA[8*h_alu[1:0] +: 8];
    ld_h = h_alu[1] ? DMEM_RDATA[31:16] : DMEM_RDATA[15:0];
    case (h_rw[1:0])
      2'b00:   ld_data = {{24{~h_rw[2] & ld_b[7]}}, ld_b};
      2'b01:   ld_data = {{16{~h_rw[2] & ld_h[15]}}, ld_h};
      default: ld_data = DMEM_RDATA;
    endcase
  end

  logic is_req;
  assign is_req     = (state == REQ);
  assign STALL_OUT  = !in_idle;
  assign DMEM_REQ   = is_req;
  assign DMEM_WE    = is_req & h_rw[3];
  assign DMEM_ADDR  = is_req ? {h_alu[31:2], 2'b00} : '0;
  assign DMEM_WDATA = is_req ? wdata : '0;
  assign DMEM_BE    = is_req ? be : '0;

  logic [31:0] wb;
  always_comb begin
    case (s_wbsel)
      2'b00:   wb = s_alu;
      2'b01:   wb = (state == WAIT_DATA) ? ld_data : '0;
      2'b10:   wb = s_pc + PC_INC;
      default: wb = s_imm;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT_VALID <= 1'b0; OUT_RD <= '0; OUT_WB_DATA <= '0;
      OUT_REG_WRITE_EN <= 1'b0; OUT_MISALIGN <= 1'b0; OUT_BUS_ERR <= 1'b0;
    end else begin
      OUT_VALID        <= retire;
      OUT_MISALIGN     <= misal;
      OUT_BUS_ERR      <= bus_err;
      OUT_REG_WRITE_EN <= retire & s_we & ~misal & ~bus_err;
      if (retire) begin
        OUT_RD      <= s_rd;
        OUT_WB_DATA <= wb;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU/store/load/misalign/timeout/reset cases.
module tb_mem_access_stage;
  logic        CLK = 1'b0, RST = 1'b1;
  logic        IN_VALID = 0, IN_DATAMEMSEL = 0, IN_REG_WRITE_EN = 0;
  logic [4:0]  IN_RD = 0;
  logic [31:0] IN_PC = 0, IN_ALU_RESULT = 0, IN_DATA2 = 0, IN_IMMEDIATE = 0;
  logic [3:0]  IN_READ_WRITE = 0;
  logic [1:0]  IN_WB_SEL = 0;
  logic        STALL_OUT, DMEM_REQ, DMEM_WE;
  logic [31:0] DMEM_ADDR, DMEM_WDATA;
  logic [3:0]  DMEM_BE;
  logic        DMEM_READY = 0, DMEM_RVALID = 0;
  logic [31:0] DMEM_RDATA = 0;
  logic        OUT_VALID, OUT_REG_WRITE_EN, OUT_MISALIGN, OUT_BUS_ERR;
  logic [4:0]  OUT_RD;
  logic [31:0] OUT_WB_DATA;
  int checks = 0, errors = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(4), .PC_INC(32'd4)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_RD(IN_RD), .IN_PC(IN_PC),
    .IN_ALU_RESULT(IN_ALU_RESULT), .IN_DATA2(IN_DATA2), .IN_IMMEDIATE(IN_IMMEDIATE),
    .IN_DATAMEMSEL(IN_DATAMEMSEL), .IN_READ_WRITE(IN_READ_WRITE), .IN_WB_SEL(IN_WB_SEL),
    .IN_REG_WRITE_EN(IN_REG_WRITE_EN), .STALL_OUT(STALL_OUT), .DMEM_REQ(DMEM_REQ),
    .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA), .DMEM_BE(DMEM_BE),
    .DMEM_READY(DMEM_READY), .DMEM_RVALID(DMEM_RVALID), .DMEM_RDATA(DMEM_RDATA),
    .OUT_VALID(OUT_VALID), .OUT_RD(OUT_RD), .OUT_WB_DATA(OUT_WB_DATA),
    .OUT_REG_WRITE_EN(OUT_REG_WRITE_EN), .OUT_MISALIGN(OUT_MISALIGN), .OUT_BUS_ERR(OUT_BUS_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [4:0] rd, input logic [31:0] pc, alu, d2, imm,
                    input logic memsel, input logic [3:0] rw, input logic [1:0] wbsel,
                    input logic we);
    IN_VALID = 1; IN_RD = rd; IN_PC = pc; IN_ALU_RESULT = alu; IN_DATA2 = d2;
    IN_IMMEDIATE = imm; IN_DATAMEMSEL = memsel; IN_READ_WRITE = rw;
    IN_WB_SEL = wbsel; IN_REG_WRITE_EN = we;
  endtask

  // Load with READY in the first REQ cycle and RVALID one cycle later.
  task automatic do_load(input string tag, input logic [3:0] rw, input logic [31:0] addr,
                         input logic [31:0] exp);
    op(5'd7, 32'h0, addr, 32'h0, 32'h0, 1'b1, rw, 2'b01, 1'b1);
    tick();
    IN_VALID = 0; DMEM_READY = 1;
    chk({tag, " req"}, {31'b0, DMEM_REQ}, 32'd1);
    chk({tag, " be"}, {28'b0, DMEM_BE}, 32'hF);
    chk({tag, " we"}, {31'b0, DMEM_WE}, 32'd0);
    tick();
    DMEM_READY = 0; DMEM_RVALID = 1; DMEM_RDATA = 32'h80F00000;
    chk({tag, " wait req"}, {31'b0, DMEM_REQ}, 32'd0);
    chk({tag, " wait stall"}, {31'b0, STALL_OUT}, 32'd1);
    tick();
    DMEM_RVALID = 0;
    chk({tag, " valid"}, {31'b0, OUT_VALID}, 32'd1);
    chk({tag, " data"}, OUT_WB_DATA, exp);
    chk({tag, " regwe"}, {31'b0, OUT_REG_WRITE_EN}, 32'd1);
  endtask

  initial begin
    #2;
    chk("rst valid", {31'b0, OUT_VALID}, 32'd0);
    chk("rst req", {31'b0, DMEM_REQ}, 32'd0);
    chk("rst stall", {31'b0, STALL_OUT}, 32'd0);
    chk("rst be", {28'b0, DMEM_BE}, 32'd0);
    tick(); RST = 0; tick();

    // Non-memory ALU op
    op(5'd5, 32'h0, 32'h1234, 32'h0, 32'h0, 1'b0, 4'b0000, 2'b00, 1'b1);
    tick();
    IN_VALID = 0;
    chk("alu valid", {31'b0, OUT_VALID}, 32'd1);
    chk("alu data", OUT_WB_DATA, 32'h1234);
    chk("alu rd", {27'b0, OUT_RD}, 32'd5);
    chk("alu stall", {31'b0, STALL_OUT}, 32'd0);
    chk("alu regwe", {31'b0, OUT_REG_WRITE_EN}, 32'd1);
    tick();
    chk("alu pulse", {31'b0, OUT_VALID}, 32'd0);

    // Store byte at 0x103, READY on third REQ cycle
    op(5'd0, 32'h0, 32'h103, 32'hAABBCCDD, 32'h0, 1'b1, 4'b1000, 2'b00, 1'b0);
    tick();
    IN_VALID = 0;
    for (int i = 0; i < 3; i++) begin
      chk("sb req", {31'b0, DMEM_REQ}, 32'd1);
      chk("sb stall", {31'b0, STALL_OUT}, 32'd1);
      chk("sb addr", DMEM_ADDR, 32'h100);
      chk("sb be", {28'b0, DMEM_BE}, 32'h8);
      chk("sb wdata", DMEM_WDATA, 32'hDDDDDDDD);
      chk("sb we", {31'b0, DMEM_WE}, 32'd1);
      chk("sb no retire", {31'b0, OUT_VALID}, 32'd0);
      if (i == 2) DMEM_READY = 1;
      tick();
    end
    DMEM_READY = 0;
    chk("sb retire", {31'b0, OUT_VALID}, 32'd1);
    chk("sb stall end", {31'b0, STALL_OUT}, 32'd0);
    chk("sb req end", {31'b0, DMEM_REQ}, 32'd0);
    chk("sb buserr", {31'b0, OUT_BUS_ERR}, 32'd0);

    // Half store lane check at addr 0x102
    op(5'd0, 32'h0, 32'h102, 32'h11223344, 32'h0, 1'b1, 4'b1001, 2'b00, 1'b0);
    tick();
    IN_VALID = 0; DMEM_READY = 1;
    chk("sh be", {28'b0, DMEM_BE}, 32'hC);
    chk("sh wdata", DMEM_WDATA, 32'h33443344);
    tick();
    DMEM_READY = 0;

    do_load("lh", 4'b0001, 32'h102, 32'hFFFF80F0);
    do_load("lhu", 4'b0101, 32'h102, 32'h000080F0);
    do_load("lb", 4'b0000, 32'h103, 32'hFFFFFF80);
    do_load("lw", 4'b0010, 32'h100, 32'h80F00000);

    // Misaligned word load
    op(5'd9, 32'h0, 32'h101, 32'h0, 32'h0, 1'b1, 4'b0010, 2'b01, 1'b1);
    #2;
    chk("mis no req pre", {31'b0, DMEM_REQ}, 32'd0);
    tick();
    IN_VALID = 0;
    chk("mis req", {31'b0, DMEM_REQ}, 32'd0);
    chk("mis valid", {31'b0, OUT_VALID}, 32'd1);
    chk("mis flag", {31'b0, OUT_MISALIGN}, 32'd1);
    chk("mis regwe", {31'b0, OUT_REG_WRITE_EN}, 32'd0);
    chk("mis stall", {31'b0, STALL_OUT}, 32'd0);
    tick();
    chk("mis flag clr", {31'b0, OUT_MISALIGN}, 32'd0);

    // Timeout: READY never comes
    op(5'd3, 32'h0, 32'h200, 32'h0, 32'h0, 1'b1, 4'b0010, 2'b01, 1'b1);
    tick();
    IN_VALID = 0;
    for (int i = 0; i < 4; i++) begin
      chk("tmo req", {31'b0, DMEM_REQ}, 32'd1);
      tick();
    end
    chk("tmo req drop", {31'b0, DMEM_REQ}, 32'd0);
    chk("tmo valid", {31'b0, OUT_VALID}, 32'd1);
    chk("tmo buserr", {31'b0, OUT_BUS_ERR}, 32'd1);
    chk("tmo regwe", {31'b0, OUT_REG_WRITE_EN}, 32'd0);
    chk("tmo stall", {31'b0, STALL_OUT}, 32'd0);
    tick();
    chk("tmo buserr clr", {31'b0, OUT_BUS_ERR}, 32'd0);

    // Store with READY in the fourth REQ cycle: completion beats timeout
    op(5'd0, 32'h0, 32'h300, 32'h55, 32'h0, 1'b1, 4'b1010, 2'b00, 1'b0);
    tick();
    IN_VALID = 0;
    for (int i = 0; i < 3; i++) begin
      chk("late req", {31'b0, DMEM_REQ}, 32'd1);
      tick();
    end
    DMEM_READY = 1;
    tick();
    DMEM_READY = 0;
    chk("late valid", {31'b0, OUT_VALID}, 32'd1);
    chk("late buserr", {31'b0, OUT_BUS_ERR}, 32'd0);

    // Reset while in REQ drops DMEM_REQ immediately
    op(5'd4, 32'h0, 32'h100, 32'h0, 32'h0, 1'b1, 4'b0010, 2'b01, 1'b1);
    tick();
    IN_VALID = 0;
    chk("rq req", {31'b0, DMEM_REQ}, 32'd1);
    #1 RST = 1; #1;
    chk("rq rst req", {31'b0, DMEM_REQ}, 32'd0);
    chk("rq rst stall", {31'b0, STALL_OUT}, 32'd0);
    RST = 0;
    tick();

    // Reset in WAIT_DATA, later RVALID ignored
    op(5'd4, 32'h0, 32'h100, 32'h0, 32'h0, 1'b1, 4'b0010, 2'b01, 1'b1);
    tick();
    IN_VALID = 0; DMEM_READY = 1;
    tick();
    DMEM_READY = 0;
    chk("rw stall", {31'b0, STALL_OUT}, 32'd1);
    #1 RST = 1; #1;
    chk("rw rst req", {31'b0, DMEM_REQ}, 32'd0);
    chk("rw rst stall", {31'b0, STALL_OUT}, 32'd0);
    chk("rw rst valid", {31'b0, OUT_VALID}, 32'd0);
    RST = 0;
    DMEM_RVALID = 1; DMEM_RDATA = 32'hDEADBEEF;
    tick();
    DMEM_RVALID = 0;
    chk("rw late rvalid", {31'b0, OUT_VALID}, 32'd0);
    chk("rw late stall", {31'b0, STALL_OUT}, 32'd0);

    // JAL link value wraps
    op(5'd1, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0, 1'b0, 4'b0000, 2'b10, 1'b1);
    tick();
    IN_VALID = 0;
    chk("jal valid", {31'b0, OUT_VALID}, 32'd1);
    chk("jal data", OUT_WB_DATA, 32'h0);
    chk("jal rd", {27'b0, OUT_RD}, 32'd1);

    // Immediate select
    op(5'd2, 32'h0, 32'h0, 32'h0, 32'hCAFE0000, 1'b0, 4'b0000, 2'b11, 1'b1);
    tick();
    IN_VALID = 0;
    chk("imm data", OUT_WB_DATA, 32'hCAFE0000);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
